// File: rtl/traffic_pkg.sv
// Shared encodings and default timing for the two-road traffic-light controller.
package traffic_pkg;

  localparam int unsigned LIGHT_W = 2;
  typedef logic [LIGHT_W-1:0] light_t;

  localparam light_t LIGHT_G = 2'b00;
  localparam light_t LIGHT_Y = 2'b01;
  localparam light_t LIGHT_R = 2'b10;

  localparam int unsigned STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    RED_AB = 3'd2,
    B_GRN  = 3'd3,
    B_YEL  = 3'd4,
    RED_BA = 3'd5
  } state_t;

  localparam int unsigned DEF_MIN_GREEN    = 4;
  localparam int unsigned DEF_MAX_GREEN    = 12;
  localparam int unsigned DEF_YELLOW_TICKS = 2;
  localparam int unsigned DEF_ALLRED_TICKS = 1;
  localparam int unsigned DEF_CNT_W        = 4;

endpackage

// File: rtl/dwell_timer.sv
// Tick-gated dwell counter with synchronous clear; saturates at all-ones.
module dwell_timer
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clear wins over counting so a phase change always starts from zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (tick && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-road Moore traffic-light controller timed in ticks from the divide-by-3 stage.
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN    = DEF_MIN_GREEN,
  parameter int unsigned MAX_GREEN    = DEF_MAX_GREEN,
  parameter int unsigned YELLOW_TICKS = DEF_YELLOW_TICKS,
  parameter int unsigned ALLRED_TICKS = DEF_ALLRED_TICKS,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tick,
  input  logic         ta,
  input  logic         tb,
  output logic [1:0]   la,
  output logic [1:0]   lb,
  output logic         phase_start
);

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] RED_LAST = CNT_W'(ALLRED_TICKS - 1);

  state_t           state;
  state_t           state_d;
  state_t           succ;
  logic             exit_met;
  logic             illegal;
  logic             clr;
  logic [CNT_W-1:0] cnt;
  light_t           la_d;
  light_t           lb_d;

  dwell_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .clr     (clr),
    .cnt     (cnt)
  );

  // Lights are registered from the next-state decode so they change with the state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= A_GRN;
      la          <= LIGHT_G;
      lb          <= LIGHT_R;
      phase_start <= 1'b0;
    end else begin
      state       <= state_d;
      la          <= la_d;
      lb          <= lb_d;
      phase_start <= (state_d != state);
    end
  end

  // Exit condition and successor of the current phase.
  always_comb begin
    exit_met = 1'b0;
    succ     = A_GRN;
    illegal  = 1'b0;
    case (state)
      A_GRN: begin
        exit_met = ((cnt >= MIN_LAST) && !ta) || ((cnt >= MAX_LAST) && tb);
        succ     = A_YEL;
      end
      A_YEL: begin
        exit_met = (cnt == YEL_LAST);
        succ     = RED_AB;
      end
      RED_AB: begin
        exit_met = (cnt == RED_LAST);
        succ     = B_GRN;
      end
      B_GRN: begin
        exit_met = ((cnt >= MIN_LAST) && !tb) || ((cnt >= MAX_LAST) && ta);
        succ     = B_YEL;
      end
      B_YEL: begin
        exit_met = (cnt == YEL_LAST);
        succ     = RED_BA;
      end
      RED_BA: begin
        exit_met = (cnt == RED_LAST);
        succ     = A_GRN;
      end
      default: illegal = 1'b1;
    endcase

    state_d = state;
    if (illegal) begin
      state_d = A_GRN;
    end else if (tick && exit_met) begin
      state_d = succ;
    end
    clr = illegal || (tick && exit_met);
  end

  // Light decode of the state being entered.
  always_comb begin
    la_d = LIGHT_R;
    lb_d = LIGHT_R;
    case (state_d)
      A_GRN:   la_d = LIGHT_G;
      A_YEL:   la_d = LIGHT_Y;
      B_GRN:   lb_d = LIGHT_G;
      B_YEL:   lb_d = LIGHT_Y;
      default: ;
    endcase
  end

endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Two-road traffic-light controller; directly downstream of the divide-by-3 tick generator.
- Consumes that stage's 1-cycle `tick` strobe as its time base. All dwell timing is counted in ticks, never in raw clocks.
- Moore FSM with a dwell counter. Drives 2-bit light codes for road A and road B from sensor inputs `ta` and `tb`.

Parameters:
- MIN_GREEN, 4: minimum ticks a road stays green (>=1).
- MAX_GREEN, 12: ticks after which green is forced to end if the other road is waiting (>MIN_GREEN).
- YELLOW_TICKS, 2: ticks in yellow (>=1).
- ALLRED_TICKS, 1: ticks both roads red between phases (>=1).
- CNT_W, 4: dwell counter width; must hold MAX_GREEN-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- tick  input  1  1-cycle enable strobe from the divide-by-3 stage; may be high on consecutive cycles.
- ta  input  1  traffic present on road A.
- tb  input  1  traffic present on road B.
- la  output  2  road A light: 2'b00 green, 2'b01 yellow, 2'b10 red.
- lb  output  2  road B light, same encoding.
- phase_start  output  1  1-cycle pulse in the first cycle of each new state.

Behaviour:
- One clock, `clk`. Reset is synchronous and active-low (`reset_n`), sampled on the rising edge of `clk`; it overrides `tick`.
- Reset values: state=A_GRN, cnt=0, la=green, lb=red, phase_start=0.
- States and outputs (Moore, decoded from state only):
  - A_GRN: la=G, lb=R
  - A_YEL: la=Y, lb=R
  - RED_AB: la=R, lb=R (clearance after A)
  - B_GRN: la=R, lb=G
  - B_YEL: la=R, lb=Y
  - RED_BA: la=R, lb=R (clearance after B)
- The state and the counter update only on cycles where tick=1; with tick=0 everything holds.
- On a tick where the exit condition is met: go to the next state and set cnt=0. Otherwise cnt=cnt+1, saturating at 2^CNT_W-1.
- Exit conditions, evaluated on the tick with the current cnt and the ta/tb values of that cycle:
  - A_GRN -> A_YEL: (cnt>=MIN_GREEN-1 and ta==0) or (cnt>=MAX_GREEN-1 and tb==1).
  - A_YEL -> RED_AB: cnt==YELLOW_TICKS-1.
  - RED_AB -> B_GRN: cnt==ALLRED_TICKS-1.
  - B_GRN -> B_YEL: mirror of A_GRN with ta/tb swapped.
  - B_YEL -> RED_BA, and RED_BA -> A_GRN: same rules as the A side.
- Green holds indefinitely while its own road has traffic and the other road has none; the counter saturates.
- Both roads idle (ta=tb=0): phases alternate at the minimum dwell times.
- Latency: the light change is visible in the cycle after the qualifying tick edge. `phase_start` is asserted that same cycle, for exactly 1 cycle.
- Unused state encodings: next state is A_GRN, cnt=0.
- Reset asserted mid-phase: next edge gives A_GRN, cnt=0, phase_start=0. No pulse is emitted on reset exit.
- Invariant: la and lb are never both non-red.

Decomposition:
- Shared package traffic_pkg holds:
  - light encodings LIGHT_G, LIGHT_Y, LIGHT_R;
  - the 3-bit state typedef/localparams for the six states;
  - default timing constants.
- One natural sub-module, `dwell_timer`: tick-gated counter with synchronous clear and saturation. Ports: clk, reset_n, tick, clr, cnt.

Test Plan:
- Idle alternation: defaults, tick every 3 clocks, ta=tb=0 from reset.
  - A green exactly 4 ticks (12 clk), yellow 2 ticks (6 clk), all-red 1 tick (3 clk), then B green.
  - Full cycle = 2*(4+2+1)=14 ticks = 42 clk.
  - phase_start pulses 6 times per cycle.
- Hold green: ta=1, tb=0 for 40 ticks.
  - la stays green throughout and cnt saturates at 15.
  - After ta drops, la goes yellow on the next tick.
- Max-green preemption: ta=1 held, tb=1 asserted at reset exit.
  - la leaves green after exactly 12 ticks.
  - B gets green after 12+2+1=15 ticks.
- Tick gating: hold tick=0 for 100 clocks mid-A_YEL → no output change. Tick held high continuously → state advances every clock, yellow lasts 2 clocks.
- Mid-operation reset: assert reset_n=0 for 1 cycle during B_GRN with tick high.
  - Next cycle: la=green, lb=red, phase_start=0.
  - Then MIN_GREEN is counted afresh.
- Safety: random ta/tb/tick for 10k cycles → la and lb never both non-red, and every green is followed by yellow, then all-red.
